battle_engine: RTL and testbench

- Turn-based battle controller that drives the game FSM's battle interface.
- Consumes start_battle, keycode and the selected team; produces end_battle, result, my_cur and enemy_cur_id, which the sprite logic uses to pick the two on-screen sprites.
- Holds hit points for the three team members and for one enemy.
- Resolves player and enemy turns with fixed turn delays and LFSR-based randomness.

---
 rtl/battle_engine.sv | 252 +++++++++++++++++++++++++
 tb/tb_battle_engine.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/battle_engine.sv
// battle_engine: turn-based battle controller for the game FSM's Battle state.
//
// Ports:
//   Clk, Reset (async, active-low)
//   start_battle, new_team    1-cycle pulses from the game FSM
//   keycode[7:0]              raw USB keycode, held while the key is down
//   my_team[2:0][2:0]         species id per team slot
//   end_battle, result        1-cycle finish pulse and win(1)/loss(0) flag
//   my_cur, enemy_cur_id      active team slot and enemy species (sprite select)
//   my_hp, enemy_hp           HP of the active slot (combinational) and of the enemy
//   menu_sel                  highlighted menu entry
//   busy                      high whenever not in IDLE
//
// Optional feature: define BATTLE_HEAL_EN to add a once-per-battle HEAL entry
// (menu index 3, +20 HP saturating at MAX_HP).
module battle_engine #(
    parameter int MAX_HP       = 100,
    parameter int ENEMY_MAX_HP = 80,
    parameter int BASE_ATK     = 10,
    parameter int ENEMY_ATK    = 6,
    parameter int TURN_DELAY   = 16
) (
    input  logic            Clk,
    input  logic            Reset,
    input  logic            start_battle,
    input  logic            new_team,
    input  logic [7:0]      keycode,
    input  logic [2:0][2:0] my_team,
    output logic            end_battle,
    output logic            result,
    output logic [1:0]      my_cur,
    output logic [2:0]      enemy_cur_id,
    output logic [7:0]      my_hp,
    output logic [7:0]      enemy_hp,
    output logic [1:0]      menu_sel,
    output logic            busy
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_PTURN = 3'd1;
    localparam logic [2:0] S_PACT  = 3'd2;
    localparam logic [2:0] S_EACT  = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [7:0] K_W     = 8'h1A;
    localparam logic [7:0] K_S     = 8'h16;
    localparam logic [7:0] K_ENTER = 8'h28;

    localparam logic [1:0] A_ATTACK = 2'd0;
    localparam logic [1:0] A_HEAVY  = 2'd1;
    localparam logic [1:0] A_SWITCH = 2'd2;
`ifdef BATTLE_HEAL_EN
    localparam logic [1:0] A_HEAL    = 2'd3;
    localparam logic [1:0] MENU_LAST = 2'd3;
`else
    localparam logic [1:0] MENU_LAST = 2'd2;
`endif

    localparam logic [7:0]  MAX8     = 8'(MAX_HP);
    localparam logic [15:0] DLY_LAST = 16'(TURN_DELAY - 1);

    logic [2:0]       state_q, state_d;
    logic [2:0][7:0]  hp_q, hp_d;
    logic [7:0]       enemy_hp_q, enemy_hp_d;
    logic [1:0]       my_cur_q, my_cur_d;
    logic [2:0]       enemy_id_q, enemy_id_d;
    logic [1:0]       menu_q, menu_d;
    logic [1:0]       action_q, action_d;
    logic             end_q, end_d;
    logic             result_q, result_d;
    logic             busy_q, busy_d;
    logic [15:0]      lfsr_q, lfsr_d;
    logic [15:0]      dly_q, dly_d;
    logic [7:0]       key_prev_q, key_prev_d;
`ifdef BATTLE_HEAL_EN
    logic             heal_used_q, heal_used_d;
    logic [8:0]       heal_sum;
`endif

    logic       key_evt, key_w, key_s, key_enter;
    logic [7:0] atk;
    logic [8:0] edmg;

    // Next alive slot strictly after cur (wrapping); cur itself if none.
    function automatic logic [1:0] next_alive(input logic [1:0] cur, input logic [2:0][7:0] hp);
        logic [1:0] n1, n2;
        n1 = (cur == 2'd2) ? 2'd0 : cur + 2'd1;
        n2 = (n1 == 2'd2) ? 2'd0 : n1 + 2'd1;
        if (hp[n1] != 8'd0) return n1;
        if (hp[n2] != 8'd0) return n2;
        return cur;
    endfunction

    function automatic logic [7:0] sat_sub(input logic [7:0] a, input logic [8:0] b);
        return ({1'b0, a} <= b) ? 8'd0 : a - b[7:0];
    endfunction

    // Edge-detected keys: a held key yields one event on its first cycle.
    assign key_evt   = (keycode != key_prev_q);
    assign key_w     = key_evt && (keycode == K_W);
    assign key_s     = key_evt && (keycode == K_S);
    assign key_enter = key_evt && (keycode == K_ENTER);

    assign atk  = 8'(BASE_ATK) + {4'd0, my_team[my_cur_q], 1'b0};
    assign edmg = {1'b0, 8'(ENEMY_ATK)} + {6'd0, lfsr_q[2:0]};

    always_comb begin
        state_d    = state_q;
        hp_d       = hp_q;
        enemy_hp_d = enemy_hp_q;
        my_cur_d   = my_cur_q;
        enemy_id_d = enemy_id_q;
        menu_d     = menu_q;
        action_d   = action_q;
        result_d   = result_q;
        dly_d      = dly_q;
        key_prev_d = keycode;
        // Fibonacci taps 16,14,13,11 in right-shift form.
        lfsr_d     = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
`ifdef BATTLE_HEAL_EN
        heal_used_d = heal_used_q;
        heal_sum    = {1'b0, hp_q[my_cur_q]} + 9'd20;
`endif
        case (state_q)
            S_IDLE: begin
                if (new_team) begin
                    hp_d     = {3{MAX8}};
                    my_cur_d = 2'd0;
                end
                if (start_battle) begin
                    enemy_id_d = lfsr_q[2:0];
                    enemy_hp_d = 8'(ENEMY_MAX_HP);
                    menu_d     = 2'd0;
                    result_d   = 1'b0;
`ifdef BATTLE_HEAL_EN
                    heal_used_d = 1'b0;
`endif
                    state_d    = S_PTURN;
                end
            end
            S_PTURN: begin
                if (key_enter) begin
                    action_d = menu_q;
                    dly_d    = 16'd0;
                    state_d  = S_PACT;
                end else if (key_w) begin
                    menu_d = (menu_q == 2'd0) ? MENU_LAST : menu_q - 2'd1;
                end else if (key_s) begin
                    menu_d = (menu_q == MENU_LAST) ? 2'd0 : menu_q + 2'd1;
                end
            end
            S_PACT: begin
                if (dly_q == 16'd0) begin
                    case (action_q)
                        A_ATTACK: enemy_hp_d = sat_sub(enemy_hp_q, {1'b0, atk});
                        A_HEAVY:  if (lfsr_q[3]) enemy_hp_d = sat_sub(enemy_hp_q, {atk, 1'b0});
                        A_SWITCH: my_cur_d = next_alive(my_cur_q, hp_q);
`ifdef BATTLE_HEAL_EN
                        A_HEAL: if (!heal_used_q) begin
                            hp_d[my_cur_q] = (heal_sum > {1'b0, MAX8}) ? MAX8 : heal_sum[7:0];
                            heal_used_d    = 1'b1;
                        end
`endif
                        default: ;
                    endcase
                end
                // Decide on the post-action value so TURN_DELAY = 1 works too.
                if (dly_q == DLY_LAST) begin
                    dly_d = 16'd0;
                    if (enemy_hp_d == 8'd0) begin
                        result_d = 1'b1;
                        state_d  = S_DONE;
                    end else begin
                        state_d  = S_EACT;
                    end
                end else begin
                    dly_d = dly_q + 16'd1;
                end
            end
            S_EACT: begin
                if (dly_q == 16'd0) hp_d[my_cur_q] = sat_sub(hp_q[my_cur_q], edmg);
                if (dly_q == DLY_LAST) begin
                    dly_d = 16'd0;
                    if (hp_d[my_cur_q] != 8'd0) begin
                        state_d = S_PTURN;
                    end else if (next_alive(my_cur_q, hp_d) != my_cur_q) begin
                        my_cur_d = next_alive(my_cur_q, hp_d);
                        state_d  = S_PTURN;
                    end else begin
                        result_d = 1'b0;
                        state_d  = S_DONE;
                    end
                end else begin
                    dly_d = dly_q + 16'd1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        // Registered outputs track the state being entered.
        end_d  = (state_d == S_DONE);
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q    <= S_IDLE;
            hp_q       <= {3{MAX8}};
            enemy_hp_q <= 8'd0;
            my_cur_q   <= 2'd0;
            enemy_id_q <= 3'd0;
            menu_q     <= 2'd0;
            action_q   <= 2'd0;
            end_q      <= 1'b0;
            result_q   <= 1'b0;
            busy_q     <= 1'b0;
            lfsr_q     <= 16'hACE1;
            dly_q      <= 16'd0;
            key_prev_q <= 8'd0;
`ifdef BATTLE_HEAL_EN
            heal_used_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            hp_q       <= hp_d;
            enemy_hp_q <= enemy_hp_d;
            my_cur_q   <= my_cur_d;
            enemy_id_q <= enemy_id_d;
            menu_q     <= menu_d;
            action_q   <= action_d;
            end_q      <= end_d;
            result_q   <= result_d;
            busy_q     <= busy_d;
            lfsr_q     <= lfsr_d;
            dly_q      <= dly_d;
            key_prev_q <= key_prev_d;
`ifdef BATTLE_HEAL_EN
            heal_used_q <= heal_used_d;
`endif
        end
    end

    assign end_battle   = end_q;
    assign result       = result_q;
    assign my_cur       = my_cur_q;
    assign enemy_cur_id = enemy_id_q;
    assign my_hp        = hp_q[my_cur_q];
    assign enemy_hp     = enemy_hp_q;
    assign menu_sel     = menu_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_battle_engine.sv
// Directed bench for battle_engine: expected values come from a small
// model of team/enemy HP and a reference LFSR; results go through a
// scoreboard queue and are compared with immediate assertions.
module tb_battle_engine;
    localparam int TD = 16;
    localparam logic [7:0] K_W = 8'h1A, K_S = 8'h16, K_ENTER = 8'h28;
`ifdef BATTLE_HEAL_EN
    localparam int NMENU = 4;
`else
    localparam int NMENU = 3;
`endif

    logic            Clk, Reset, start_battle, new_team;
    logic [7:0]      keycode;
    logic [2:0][2:0] my_team;
    logic            end_battle, result, busy;
    logic [1:0]      my_cur, menu_sel;
    logic [2:0]      enemy_cur_id;
    logic [7:0]      my_hp, enemy_hp;

    int errors = 0, checks = 0;
    string       sb_tag[$];
    logic [15:0] sb_exp[$];
    logic [15:0] m_lfsr;
    int tb_hp[3];
    int tb_cur, tb_ehp, tb_menu;
    bit tb_heal;

    battle_engine #(.TURN_DELAY(TD)) dut (
        .Clk(Clk), .Reset(Reset), .start_battle(start_battle), .new_team(new_team),
        .keycode(keycode), .my_team(my_team), .end_battle(end_battle), .result(result),
        .my_cur(my_cur), .enemy_cur_id(enemy_cur_id), .my_hp(my_hp), .enemy_hp(enemy_hp),
        .menu_sel(menu_sel), .busy(busy)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    // Reference 16-bit LFSR, seed ACE1, taps 16/14/13/11.
    always @(posedge Clk or negedge Reset) begin
        if (!Reset) m_lfsr <= 16'hACE1;
        else        m_lfsr <= {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic sb_push(input string tag, input int exp);
        sb_tag.push_back(tag);
        sb_exp.push_back(16'(exp));
    endtask

    task automatic sb_pop(input logic [15:0] obs);
        string t;
        logic [15:0] e;
        if (sb_exp.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_empty: observed %0d expected an entry", obs);
            return;
        end
        t = sb_tag.pop_front();
        e = sb_exp.pop_front();
        chk(t, obs, e);
    endtask

    function automatic int sat(input int a, input int b);
        return (a > b) ? a - b : 0;
    endfunction

    function automatic int next_alive(input int cur);
        for (int k = 1; k < 3; k++)
            if (tb_hp[(cur + k) % 3] > 0) return (cur + k) % 3;
        return cur;
    endfunction

    task automatic press(input logic [7:0] code, input int hold);
        keycode = code;
        repeat (hold) tick();
        keycode = 8'h00;
        tick();
    endtask

    task automatic begin_battle();
        logic [2:0] eid;
        eid = m_lfsr[2:0];
        start_battle = 1'b1;
        tick();
        start_battle = 1'b0;
        tb_ehp = 80; tb_menu = 0; tb_heal = 0;
        chk("start_enemy_id", enemy_cur_id, eid);
        chk("start_enemy_hp", enemy_hp, 80);
        chk("start_menu", menu_sel, 0);
        chk("start_result", result, 0);
        chk("start_busy", busy, 1);
    endtask

    // One full player turn plus the enemy reply (if any).
    task automatic play_turn(input int act, output bit done);
        logic [15:0] lfa, lfb;
        int atk, n, pre_e;
        done = 1'b0;
        n = (act - tb_menu + NMENU) % NMENU;
        repeat (n) press(K_S, 2);
        tb_menu = act;
        chk("menu_nav", menu_sel, 16'(act));
        pre_e = tb_ehp;
        keycode = K_ENTER;
        tick();
        keycode = 8'h00;
        lfa = m_lfsr;
        atk = 10 + 2 * int'(my_team[tb_cur]);
        case (act)
            0: tb_ehp = sat(tb_ehp, atk);
            1: if (lfa[3]) tb_ehp = sat(tb_ehp, 2 * atk);
            2: tb_cur = next_alive(tb_cur);
            3: if (!tb_heal) begin
                tb_hp[tb_cur] = (tb_hp[tb_cur] + 20 > 100) ? 100 : tb_hp[tb_cur] + 20;
                tb_heal = 1'b1;
            end
            default: ;
        endcase
        sb_push("act_enemy_hp", tb_ehp);
        sb_push("act_my_cur", tb_cur);
        sb_push("act_my_hp", tb_hp[tb_cur]);
        chk("act_entry_enemy_hp", enemy_hp, 16'(pre_e));
        tick();
        sb_pop(enemy_hp);
        sb_pop(my_cur);
        sb_pop(my_hp);
        if (tb_ehp == 0) begin
            repeat (TD - 1) tick();
            chk("win_end_pulse", end_battle, 1);
            chk("win_result", result, 1);
            tick();
            chk("win_end_clear", end_battle, 0);
            chk("win_idle", busy, 0);
            done = 1'b1;
            return;
        end
        repeat (TD - 1) tick();
        chk("enemy_not_early", my_hp, 16'(tb_hp[tb_cur]));
        lfb = m_lfsr;
        tick();
        tb_hp[tb_cur] = sat(tb_hp[tb_cur], 6 + int'(lfb[2:0]));
        sb_push("enemy_hit_hp", tb_hp[tb_cur]);
        sb_pop(my_hp);
        repeat (TD - 1) tick();
        if (tb_hp[tb_cur] == 0 && next_alive(tb_cur) == tb_cur) begin
            chk("loss_end_pulse", end_battle, 1);
            chk("loss_result", result, 0);
            chk("loss_my_cur", my_cur, 16'(tb_cur));
            tick();
            chk("loss_end_clear", end_battle, 0);
            chk("loss_idle", busy, 0);
            done = 1'b1;
        end else begin
            if (tb_hp[tb_cur] == 0) tb_cur = next_alive(tb_cur);
            sb_push("cur_after_enemy", tb_cur);
            sb_pop(my_cur);
            chk("turn_no_end", end_battle, 0);
            chk("turn_busy", busy, 1);
        end
    endtask

    initial begin
        bit done;
        logic [2:0] eid1;
        int n;
        Reset = 1'b0; start_battle = 1'b0; new_team = 1'b0; keycode = 8'h00;
        my_team[0] = 3'd1; my_team[1] = 3'd2; my_team[2] = 3'd3;
        for (int i = 0; i < 3; i++) tb_hp[i] = 100;
        tb_cur = 0; tb_ehp = 0; tb_menu = 0; tb_heal = 1'b0;
        tick(); tick();
        chk("rst_busy", busy, 0);
        chk("rst_my_hp", my_hp, 100);
        chk("rst_enemy_hp", enemy_hp, 0);
        chk("rst_my_cur", my_cur, 0);
        chk("rst_end", end_battle, 0);
        chk("rst_menu", menu_sel, 0);
        Reset = 1'b1;
        tick();

        // Battle 1: menu walk, then win by repeated ATTACK (atk = 12).
        begin_battle();
        eid1 = enemy_cur_id;
        press(K_S, 100);
        chk("menu_s_held", menu_sel, 1);
        press(K_S, 1);
        chk("menu_s_2", menu_sel, 2);
        press(K_S, 1);
        chk("menu_s_wrap", menu_sel, 16'(3 % NMENU));
        if (NMENU == 4) press(K_S, 1);
        press(8'h04, 3);
        chk("menu_other_key", menu_sel, 0);
        press(K_W, 5);
        chk("menu_w_wrap", menu_sel, 16'(NMENU - 1));
        press(K_S, 1);
        chk("menu_back_0", menu_sel, 0);
        tb_menu = 0;
        play_turn(0, done);
        chk("first_attack_enemy_hp", enemy_hp, 68);
        new_team = 1'b1; tick(); new_team = 1'b0;
        chk("new_team_ignored", my_hp, 16'(tb_hp[0]));
        start_battle = 1'b1; tick(); start_battle = 1'b0;
        chk("start_ignored_hp", enemy_hp, 16'(tb_ehp));
        chk("start_ignored_id", enemy_cur_id, eid1);
        n = 0;
        while (!done && n < 12) begin play_turn(0, done); n++; end
        chk("win_reached", done, 1);

        // Battle 2: HP persists; always SWITCH until every slot falls.
        begin_battle();
        chk("hp_persists", my_hp, 16'(tb_hp[tb_cur]));
        done = 1'b0; n = 0;
        while (!done && n < 80) begin play_turn(2, done); n++; end
        chk("loss_reached", done, 1);

        // Battle 3: fresh team, HEAVY/SWITCH (and HEAL), then reset mid-action.
        new_team = 1'b1; tick(); new_team = 1'b0;
        for (int i = 0; i < 3; i++) tb_hp[i] = 100;
        tb_cur = 0;
        chk("new_team_hp", my_hp, 100);
        chk("new_team_cur", my_cur, 0);
        begin_battle();
        play_turn(0, done);
`ifdef BATTLE_HEAL_EN
        play_turn(3, done);
        chk("heal_full", my_hp >= 8'd87 ? 16'd1 : 16'd0, 1);
        play_turn(3, done);
`endif
        play_turn(1, done);
        play_turn(2, done);
        chk("switch_to_1", my_cur, 1);
        n = (0 - tb_menu + NMENU) % NMENU;
        repeat (n) press(K_S, 2);
        keycode = K_ENTER; tick(); keycode = 8'h00;
        tick(); tick();
        Reset = 1'b0;
        tick();
        chk("midrst_busy", busy, 0);
        chk("midrst_my_hp", my_hp, 100);
        chk("midrst_my_cur", my_cur, 0);
        chk("midrst_enemy_hp", enemy_hp, 0);
        chk("midrst_end", end_battle, 0);
        chk("midrst_enemy_id", enemy_cur_id, 0);
        Reset = 1'b1;
        tick(); tick();
        chk("post_rst_idle", busy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
